// File: rtl/corelet_acc_ctrl.sv
// corelet_acc_ctrl
// Output-path and mode controller for the corelet MAC array.
//   * Builds the north-edge weight feed from the IFIFO (zero- or sign-extended
//     to psum_bw). The feed is forced to 0 in weight-stationary mode.
//   * Drains the OFIFO. In WS mode, words accumulate across passes into an
//     acc_depth-entry per-column bank. In OS mode, words pass straight through.
//   * Sequences WS/OS switches RUN -> DRAIN -> SWITCH -> RUN, so the array and
//     the OFIFO are empty before `mode` changes.
// Optional feature: define CORELET_RELU_EN to clamp negative final_out
//   columns to 0 in both modes. The bank keeps the unclamped sums.
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   mode_req/_valid         requested mode (0=WS, 1=OS) and its one-cycle strobe
//   mode, mode_busy         current mode, switch in progress
//   array_idle              array has nothing in flight
//   ififo_data, north_out   weight feed in / array north input out
//   ofifo_out/_valid/_rd    OFIFO show-ahead data, non-empty flag, pop
//   acc_clear/_len/_last    new accumulation set, words per pass, final pass
//   final_out, final_valid  result and its one-cycle pulse
//   dbg_state_o             FSM state (0=RUN, 1=DRAIN, 2=SWITCH)
// Handshake: the OFIFO is show-ahead. When ofifo_rd is high, ofifo_out is
//   consumed on that same clock edge. final_valid has no backpressure.
module corelet_acc_ctrl #(
  parameter int col           = 8,
  parameter int bw            = 4,
  parameter int psum_bw       = 16,
  parameter int acc_depth     = 16,
  parameter int weight_signed = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode_req,
  input  logic                         mode_req_valid,
  output logic                         mode,
  output logic                         mode_busy,
  input  logic                         array_idle,
  input  logic [col*bw-1:0]            ififo_data,
  output logic [col*psum_bw-1:0]       north_out,
  input  logic [col*psum_bw-1:0]       ofifo_out,
  input  logic                         ofifo_valid,
  output logic                         ofifo_rd,
  input  logic                         acc_clear,
  input  logic [$clog2(acc_depth):0]   acc_len,
  input  logic                         acc_last,
  output logic [col*psum_bw-1:0]       final_out,
  output logic                         final_valid,
  output logic [1:0]                   dbg_state_o
);
  localparam int AW = $clog2(acc_depth);
  localparam int LW = AW + 1;
  localparam int W  = col * psum_bw;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_SWITCH = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            mode_q, req_q;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic            first_q, first_d;
  logic [LW-1:0]   len_q, len_d;
  logic [W-1:0]    final_q, final_d;
  logic            fv_q, fv_d;
  logic [W-1:0]    bank_q [acc_depth];

  logic [AW-1:0]   wp_eff;
  logic            first_eff;
  logic [LW-1:0]   len_eff;
  logic            wrap;
  logic [W-1:0]    sum_row;
  logic            ws_pop, os_pop;

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
`ifdef CORELET_RELU_EN
    for (int i = 0; i < col; i++)
      if (v[i*psum_bw+psum_bw-1]) r[i*psum_bw +: psum_bw] = '0;
`endif
    return r;
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (mode_req_valid && (mode_req != mode_q)) state_d = ST_DRAIN;
      ST_DRAIN:  if (array_idle && !ofifo_valid) state_d = ST_SWITCH;
      ST_SWITCH: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mode_busy   = (state_q != ST_RUN);
    ofifo_rd    = ofifo_valid && (state_q != ST_SWITCH);
    dbg_state_o = state_q;
  end

  // The mode target is latched at request time. Requests made while busy are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      if (state_q == ST_RUN && mode_req_valid) req_q <= mode_req;
      if (state_q == ST_SWITCH) mode_q <= req_q;
    end
  end

  assign mode = mode_q;

  // North feed: extension of each IFIFO nibble. It is forced to 0 in WS mode.
  always_comb begin
    north_out = '0;
    for (int i = 0; i < col; i++) begin
      if (mode_q) begin
        if (weight_signed != 0)
          north_out[i*psum_bw +: psum_bw] =
            {{(psum_bw-bw){ififo_data[i*bw+bw-1]}}, ififo_data[i*bw +: bw]};
        else
          north_out[i*psum_bw +: psum_bw] = {{(psum_bw-bw){1'b0}}, ififo_data[i*bw +: bw]};
      end
    end
  end

  // acc_clear is applied before a coincident pop: that pop is a first-pass
  // write to entry 0. The pass length is resampled only at pointer 0.
  always_comb begin
    ws_pop    = ofifo_rd && !mode_q;
    os_pop    = ofifo_rd && mode_q;
    wp_eff    = acc_clear ? '0 : wptr_q;
    first_eff = acc_clear | first_q;
    len_eff   = (wp_eff == '0) ? acc_len : len_q;
    wrap      = ({1'b0, wp_eff} == (len_eff - LW'(1)));
    for (int i = 0; i < col; i++)
      sum_row[i*psum_bw +: psum_bw] =
        (first_eff ? '0 : bank_q[wp_eff][i*psum_bw +: psum_bw]) + ofifo_out[i*psum_bw +: psum_bw];
  end

  always_comb begin
    wptr_d  = wp_eff;
    first_d = first_eff;
    len_d   = len_eff;
    final_d = final_q;
    fv_d    = 1'b0;
    if (state_q == ST_SWITCH) begin
      wptr_d  = '0;
      first_d = 1'b1;
    end else if (ws_pop) begin
      wptr_d  = wrap ? '0 : wp_eff + AW'(1);
      first_d = wrap ? 1'b0 : first_eff;
    end
    if (ws_pop && acc_last) begin
      final_d = relu(sum_row);
      fv_d    = 1'b1;
    end else if (os_pop) begin
      final_d = relu(ofifo_out);
      fv_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      first_q <= 1'b1;
      len_q   <= LW'(acc_depth);
      final_q <= '0;
      fv_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      first_q <= first_d;
      len_q   <= len_d;
      final_q <= final_d;
      fv_q    <= fv_d;
    end
  end

  // The bank is not reset. Every entry gets a first-pass write before it is read.
  always_ff @(posedge clk) begin
    if (!reset && ws_pop) bank_q[wp_eff] <= sum_row;
  end

  assign final_out   = final_q;
  assign final_valid = fv_q;

endmodule

// File: tb/tb_corelet_acc_ctrl.sv
module tb_corelet_acc_ctrl;
  localparam int COL = 8, BW = 4, PBW = 16, DEPTH = 16, LW = 5, W = COL * PBW;

  logic clk = 1'b0;
  logic reset, mode_req, mode_req_valid, array_idle, ofifo_valid, acc_clear, acc_last;
  logic [COL*BW-1:0] ififo_data;
  logic [W-1:0]      ofifo_out;
  logic [LW-1:0]     acc_len;
  logic              mode, mode_busy, ofifo_rd, final_valid;
  logic              mode_s, busy_s, rd_s, fv_s;
  logic [W-1:0]      north_out, north_s, final_out, final_s;
  logic [1:0]        dbg_state, dbg_s;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  corelet_acc_ctrl #(.col(COL), .bw(BW), .psum_bw(PBW), .acc_depth(DEPTH), .weight_signed(0)) dut (
    .clk(clk), .reset(reset), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode(mode), .mode_busy(mode_busy), .array_idle(array_idle), .ififo_data(ififo_data),
    .north_out(north_out), .ofifo_out(ofifo_out), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
    .acc_clear(acc_clear), .acc_len(acc_len), .acc_last(acc_last), .final_out(final_out),
    .final_valid(final_valid), .dbg_state_o(dbg_state));

  corelet_acc_ctrl #(.col(COL), .bw(BW), .psum_bw(PBW), .acc_depth(DEPTH), .weight_signed(1)) dut_s (
    .clk(clk), .reset(reset), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode(mode_s), .mode_busy(busy_s), .array_idle(array_idle), .ififo_data(ififo_data),
    .north_out(north_s), .ofifo_out(ofifo_out), .ofifo_valid(ofifo_valid), .ofifo_rd(rd_s),
    .acc_clear(acc_clear), .acc_len(acc_len), .acc_last(acc_last), .final_out(final_s),
    .final_valid(fv_s), .dbg_state_o(dbg_s));

  // reference model state
  logic            m_valid = 1'b0;
  logic            m_mode, m_pending, m_switch, m_target, m_first, m_fv;
  int              m_wp, m_len, rd_count;
  logic [PBW-1:0]  m_bank [DEPTH][COL];
  logic [W-1:0]    exp_q [$];

  typedef struct {
    logic          clr;
    logic [LW-1:0] len;
    logic [15:0]   word;
    logic          last;
    logic          exp_v;
    logic [15:0]   exp_col;
  } ws_vec_t;
  ws_vec_t ws_tab [10];

  function automatic logic [W-1:0] rep(input logic [15:0] w);
    return {COL{w}};
  endfunction

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
`ifdef CORELET_RELU_EN
    for (int c = 0; c < COL; c++)
      if (v[c*PBW+PBW-1]) r[c*PBW +: PBW] = '0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock: comb checks and the model step at negedge, registered checks at posedge+1.
  task automatic tick();
    logic [W-1:0] exp_n, exp_ns, sum;
    logic [3:0]   nib;
    logic         pop;
    logic [1:0]   exp_dbg;
    @(negedge clk);
    exp_n = '0; exp_ns = '0; sum = '0;
    for (int c = 0; c < COL; c++) begin
      nib = ififo_data[c*BW +: BW];
      if (m_mode) begin
        exp_n[c*PBW +: PBW]  = {12'h000, nib};
        exp_ns[c*PBW +: PBW] = {{12{nib[3]}}, nib};
      end
    end
    pop = ofifo_valid && !m_switch;
    exp_dbg = m_switch ? 2'd2 : (m_pending ? 2'd1 : 2'd0);
    if (m_valid) begin
      check("north_out", north_out, exp_n);
      check("north_out_signed", north_s, exp_ns);
      check1("ofifo_rd", ofifo_rd, pop);
      check1("ofifo_rd_s", rd_s, pop);
      check1("mode", mode, m_mode);
      check1("mode_s", mode_s, m_mode);
      check1("mode_busy", mode_busy, m_pending);
      check1("mode_busy_s", busy_s, m_pending);
      check("dbg_state", {126'd0, dbg_state}, {126'd0, exp_dbg});
      check("dbg_state_s", {126'd0, dbg_s}, {126'd0, exp_dbg});
    end
    if (ofifo_rd) rd_count++;
    m_fv = 1'b0;
    if (reset) begin
      m_valid = 1'b1; m_mode = 1'b0; m_pending = 1'b0; m_switch = 1'b0;
      m_wp = 0; m_first = 1'b1;
      exp_q.delete();
    end else begin
      if (acc_clear) begin m_wp = 0; m_first = 1'b1; end
      if (m_wp == 0) m_len = int'(acc_len);
      if (pop && !m_mode) begin
        for (int c = 0; c < COL; c++) begin
          m_bank[m_wp][c] = (m_first ? 16'h0000 : m_bank[m_wp][c]) + ofifo_out[c*PBW +: PBW];
          sum[c*PBW +: PBW] = m_bank[m_wp][c];
        end
        if (m_wp == m_len - 1) begin m_wp = 0; m_first = 1'b0; end
        else m_wp++;
        if (acc_last) begin exp_q.push_back(relu(sum)); m_fv = 1'b1; end
      end else if (pop && m_mode) begin
        exp_q.push_back(relu(ofifo_out)); m_fv = 1'b1;
      end
      if (m_switch) begin
        m_mode = m_target; m_switch = 1'b0; m_pending = 1'b0; m_wp = 0; m_first = 1'b1;
      end else if (m_pending) begin
        if (array_idle && !ofifo_valid) m_switch = 1'b1;
      end else if (mode_req_valid && mode_req != m_mode) begin
        m_pending = 1'b1; m_target = mode_req;
      end
    end
    @(posedge clk); #1;
    if (m_valid) begin
      check1("final_valid", final_valid, m_fv);
      check1("final_valid_s", fv_s, m_fv);
      if (m_fv) begin
        sum = exp_q.pop_front();
        check("final_out", final_out, sum);
        check("final_out_s", final_s, sum);
      end
    end
  endtask

  initial begin
    logic [15:0] wrap_exp, neg_exp;
`ifdef CORELET_RELU_EN
    wrap_exp = 16'h0000; neg_exp = 16'h0000;
`else
    wrap_exp = 16'h8000; neg_exp = 16'h8001;
`endif
    for (int i = 0; i < 4; i++) ws_tab[i] = '{1'b0, 5'd4, 16'h0003, 1'b0, 1'b0, 16'h0000};
    for (int i = 4; i < 8; i++) ws_tab[i] = '{1'b0, 5'd4, 16'h0005, 1'b1, 1'b1, 16'h0008};
    ws_tab[8] = '{1'b1, 5'd1, 16'h7FFF, 1'b0, 1'b0, 16'h0000};
    ws_tab[9] = '{1'b0, 5'd1, 16'h0001, 1'b1, 1'b1, wrap_exp};

    reset = 1'b1; mode_req = 1'b0; mode_req_valid = 1'b0; array_idle = 1'b1;
    ofifo_valid = 1'b0; ofifo_out = '0; ififo_data = '0; acc_clear = 1'b0;
    acc_len = 5'd4; acc_last = 1'b0; rd_count = 0;
    tick(); tick();
    reset = 1'b0;
    check("reset_final_out", final_out, '0);
    check1("reset_final_valid", final_valid, 1'b0);
    check1("reset_mode", mode, 1'b0);
    check1("reset_busy", mode_busy, 1'b0);
    check1("reset_ofifo_rd", ofifo_rd, 1'b0);

    // WS accumulation and wrap, table driven
    for (int i = 0; i < 10; i++) begin
      acc_clear = ws_tab[i].clr; acc_len = ws_tab[i].len; acc_last = ws_tab[i].last;
      ofifo_valid = 1'b1; ofifo_out = rep(ws_tab[i].word);
      tick();
      check1("tab_valid", final_valid, ws_tab[i].exp_v);
      if (ws_tab[i].exp_v) check("tab_final", final_out, rep(ws_tab[i].exp_col));
    end
    ofifo_valid = 1'b0; acc_clear = 1'b0; acc_last = 1'b0;
    tick();

    // WS -> OS switch with draining
    rd_count = 0;
    mode_req = 1'b1; mode_req_valid = 1'b1; array_idle = 1'b0;
    tick();
    check1("sw_busy_c1", mode_busy, 1'b1);
    mode_req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ofifo_valid = 1'b1; ofifo_out = rep(16'(i));
      tick();
      check1("sw_mode_drain", mode, 1'b0);
    end
    ofifo_valid = 1'b0;
    tick();
    check1("sw_busy_c4", mode_busy, 1'b1);
    array_idle = 1'b1;
    tick();
    check1("sw_mode_c5", mode, 1'b0);
    tick();
    check1("sw_mode_c6", mode, 1'b1);
    check1("sw_busy_c6", mode_busy, 1'b0);
    checki("sw_drain_pops", rd_count, 3);

    // OS pass-through and north extension
    ififo_data = {COL{4'hA}}; ofifo_out = rep(16'h0123); ofifo_valid = 1'b1;
    #1;
    check("os_north_u", north_out, rep(16'h000A));
    check("os_north_s", north_s, rep(16'hFFFA));
    tick();
    check1("os_valid", final_valid, 1'b1);
    check("os_final", final_out, rep(16'h0123));
    ofifo_out = rep(16'h8001);
    tick();
    check("os_final_neg", final_out, rep(neg_exp));
    ofifo_valid = 1'b0;
    tick();

    // reset in the middle of DRAIN
    mode_req = 1'b0; mode_req_valid = 1'b1; array_idle = 1'b0;
    tick();
    mode_req_valid = 1'b0;
    tick();
    check1("rd_busy_drain", mode_busy, 1'b1);
    reset = 1'b1;
    tick();
    check1("rd_mode", mode, 1'b0);
    check1("rd_busy", mode_busy, 1'b0);
    check1("rd_final_valid", final_valid, 1'b0);
    reset = 1'b0; array_idle = 1'b1;
    tick();

    // acc_clear coincident with a WS pop
    acc_len = 5'd2; acc_last = 1'b0; ofifo_valid = 1'b1;
    ofifo_out = rep(16'd9); tick();
    ofifo_out = rep(16'd4); tick();
    acc_clear = 1'b1; acc_last = 1'b1; ofifo_out = rep(16'd7); tick();
    check("clr_entry0", final_out, rep(16'd7));
    acc_clear = 1'b0; ofifo_out = rep(16'd1); tick();
    check("clr_entry1", final_out, rep(16'd1));
    ofifo_out = rep(16'd2); tick();
    check("clr_entry0_next", final_out, rep(16'd9));
    ofifo_valid = 1'b0; acc_last = 1'b0;
    tick();

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      reset          = ($urandom_range(0, 99) == 0);
      mode_req_valid = ($urandom_range(0, 7) == 0);
      mode_req       = 1'($urandom_range(0, 1));
      array_idle     = ($urandom_range(0, 3) != 0);
      ofifo_valid    = 1'($urandom_range(0, 1));
      ofifo_out      = {$urandom(), $urandom(), $urandom(), $urandom()};
      ififo_data     = $urandom();
      acc_clear      = ($urandom_range(0, 15) == 0);
      if (acc_clear) acc_len = LW'($urandom_range(1, DEPTH));
      acc_last       = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
